// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped, write-through, no-write-allocate data cache sitting
// between the CPU MEM stage and a word-wide backing memory.
//  - Load hit: answered in the LOOKUP cycle (one cycle after accept).
//  - Load miss: the whole line is refilled, then the requested word is returned.
//  - Store: merged into the cached word on a hit, always written through to
//    memory, never allocates.
// Optional feature macro: DCACHE_PERF_EN adds saturating hit/miss counters
// (hit_cnt_o, miss_cnt_o). Without it those ports and counters do not exist.
module dcache_dm #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [ADDR_W-1:0]     mem_req_addr_o,
    output logic [DATA_W-1:0]     mem_req_wdata_o,
    output logic [DATA_W/8-1:0]   mem_req_be_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_W-1:0]     mem_rsp_rdata_i
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int WRD_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - WRD_W - IDX_W;
    localparam int WA_W  = ADDR_W - OFF_W;
    // One extra bit so the request counter can express "all words issued".
    localparam int CNT_W = WRD_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(WORDS_PER_LINE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP,
        S_WRITE
    } state_t;

    // Control state
    state_t              r_state;
    logic                r_req_ready;
    logic                r_we;
    logic [WA_W-1:0]     r_waddr;   // latched word address (byte offset dropped)
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [CNT_W-1:0]    r_req_cnt;
    logic [CNT_W-1:0]    r_rsp_cnt;
    logic [LINES-1:0]    r_valid;

    // Storage arrays
    logic [DATA_W-1:0]   r_data [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]    r_tag  [LINES];

    // Address fields of the latched request
    logic [WRD_W-1:0]    w_word;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic [DATA_W-1:0]   w_cur_word;
    logic [DATA_W-1:0]   w_merged;
    logic                w_refill_hs;
    logic                w_refill_last;
    logic                w_unused;

    assign w_word     = r_waddr[WRD_W-1:0];
    assign w_idx      = r_waddr[WRD_W +: IDX_W];
    assign w_tag      = r_waddr[WA_W-1 -: TAG_W];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_cur_word = r_data[w_idx][w_word];

    // A refill read request is accepted this cycle
    assign w_refill_hs   = (r_state == S_REFILL) && (r_req_cnt != ALL_CNT) && mem_req_ready_i;
    // The final word of the line arrives this cycle
    assign w_refill_last = (r_state == S_REFILL) && mem_rsp_valid_i && (r_rsp_cnt == LAST_CNT);

    // Byte offset inside a word is irrelevant to a word-wide cache.
    assign w_unused = ^req_addr_i[OFF_W-1:0];

    // Store-hit merge: replace only the enabled bytes of the cached word
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_merged = w_cur_word;
        for (int b = 0; b < BE_W; b++) begin
            if (r_be[b]) begin
                w_merged[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    // Main FSM: request latch, refill counters, valid bits and registered ready
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we        <= req_we_i;
                        r_waddr     <= req_addr_i[ADDR_W-1:OFF_W];
                        r_wdata     <= req_wdata_i;
                        r_be        <= req_be_i;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (r_we) begin
                        r_state <= S_WRITE;
                    end else if (w_hit) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        // The old line is dropped now; it becomes valid again
                        // only once the whole new line has arrived.
                        r_req_cnt      <= '0;
                        r_rsp_cnt      <= '0;
                        r_valid[w_idx] <= 1'b0;
                        r_state        <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (w_refill_hs) begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                    if (mem_rsp_valid_i) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                    end
                    if (w_refill_last) begin
                        r_valid[w_idx] <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_WRITE: begin
                    if (mem_req_ready_i) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Data and tag arrays: written on store hits, refill responses and refill completion
    always_ff @(posedge clk) begin
        // NOTE: the arrays carry no reset; the valid bits alone decide whether their contents are meaningful.
        if ((r_state == S_LOOKUP) && r_we && w_hit) begin
            r_data[w_idx][w_word] <= w_merged;
        end
        if ((r_state == S_REFILL) && mem_rsp_valid_i) begin
            r_data[w_idx][r_rsp_cnt[WRD_W-1:0]] <= mem_rsp_rdata_i;
        end
        if (w_refill_last) begin
            r_tag[w_idx] <= w_tag;
        end
    end

    // Output decode from the registered state; everything idles at zero
    always_comb begin
        req_ready_o     = r_req_ready;
        rsp_valid_o     = 1'b0;
        rsp_rdata_o     = '0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        mem_req_wdata_o = '0;
        mem_req_be_o    = '0;
        case (r_state)
            S_LOOKUP: begin
                if (!r_we && w_hit) begin
                    rsp_valid_o = 1'b1;
                    rsp_rdata_o = w_cur_word;
                end
            end
            S_REFILL: begin
                if (r_req_cnt != ALL_CNT) begin
                    mem_req_valid_o = 1'b1;
                    mem_req_addr_o  = {w_tag, w_idx, r_req_cnt[WRD_W-1:0], {OFF_W{1'b0}}};
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = w_cur_word;
            end
            S_WRITE: begin
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {r_waddr, {OFF_W{1'b0}}};
                mem_req_wdata_o = r_wdata;
                mem_req_be_o    = r_be;
                rsp_valid_o     = mem_req_ready_i;
            end
            default: begin
            end
        endcase
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating hit/miss counters, counted once per lookup (loads and stores)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// tb_dcache_dm: self-checking bench for dcache_dm with default parameters.
// A behavioural backing memory (reads return stored data, else the address)
// answers with random stalls; a reference model tracks which line each index
// holds and what memory should contain, and predicts data and bus traffic.
module tb_dcache_dm;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;
    localparam int WPL    = 4;
    localparam int LINES  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic              req_we_i = 1'b0;
    logic [ADDR_W-1:0] req_addr_i = '0;
    logic [DATA_W-1:0] req_wdata_i = '0;
    logic [BE_W-1:0]   req_be_i = '0;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic              mem_req_we_o;
    logic [ADDR_W-1:0] mem_req_addr_o;
    logic [DATA_W-1:0] mem_req_wdata_o;
    logic [BE_W-1:0]   mem_req_be_o;
    logic              mem_rsp_valid_i;
    logic [DATA_W-1:0] mem_rsp_rdata_i;
`ifdef DCACHE_PERF_EN
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;
`endif

    dcache_dm #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_rdata_i(mem_rsp_rdata_i)
`ifdef DCACHE_PERF_EN
        , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } txn_t;

    txn_t              log_q[$];      // memory-side handshakes of the current op
    logic [ADDR_W-1:0] pend_q[$];     // read addresses awaiting a response
    logic [DATA_W-1:0] bk_mem [logic [ADDR_W-1:0]];   // what the DUT actually wrote
    logic [DATA_W-1:0] ref_mem[logic [ADDR_W-1:0]];   // what memory should hold
    bit                stall_en  = 1'b0;
    int                rsp_given = 0;

    // Reference cache model: line number held per index
    bit                ref_v   [LINES];
    logic [ADDR_W-1:0] ref_line[LINES];
    int                ref_hits   = 0;
    int                ref_misses = 0;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] bk_read(input logic [ADDR_W-1:0] a);
        return bk_mem.exists(a) ? bk_mem[a] : a;
    endfunction

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a;
    endfunction

    // Predict one request: hit/miss, expected load data; update model state
    task automatic model_op(input bit we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                            output bit hit, output logic [DATA_W-1:0] exp_data);
        int idx;
        logic [ADDR_W-1:0] ln;
        logic [ADDR_W-1:0] wa;
        idx = int'(addr[8:5]);
        ln  = addr >> 5;
        wa  = addr & ~64'h7;
        hit = ref_v[idx] && (ref_line[idx] == ln);
        if (hit) ref_hits++; else ref_misses++;
        exp_data = '0;
        if (we) begin
            ref_mem[wa] = merge(ref_read(wa), wd, be);
        end else begin
            exp_data = ref_read(wa);
            if (!hit) begin
                ref_v[idx]    = 1'b1;
                ref_line[idx] = ln;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) ref_v[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    // Describe how the logged memory traffic differs from what the op needs ("" = as expected)
    function automatic string traffic_diff(input bit we, input logic [ADDR_W-1:0] addr,
                                           input logic [DATA_W-1:0] wd,
                                           input logic [BE_W-1:0] be, input bit hit);
        logic [ADDR_W-1:0] base;
        if (we) begin
            if (log_q.size() != 1)
                return $sformatf("%0d txns, want one write", log_q.size());
            if (!log_q[0].we || log_q[0].addr !== (addr & ~64'h7) ||
                log_q[0].wdata !== wd || log_q[0].be !== be)
                return $sformatf("we=%0b addr=%h data=%h be=%h want write addr=%h data=%h be=%h",
                                 log_q[0].we, log_q[0].addr, log_q[0].wdata, log_q[0].be,
                                 addr & ~64'h7, wd, be);
            return "";
        end
        if (hit) return (log_q.size() == 0) ? "" : $sformatf("%0d txns on hit, want 0", log_q.size());
        if (log_q.size() != WPL) return $sformatf("%0d txns on miss, want %0d reads", log_q.size(), WPL);
        base = addr & ~64'h1F;
        for (int k = 0; k < WPL; k++) begin
            if (log_q[k].we || log_q[k].addr !== base + 64'(k * BE_W))
                return $sformatf("txn %0d we=%0b addr=%h want read %h", k, log_q[k].we,
                                 log_q[k].addr, base + 64'(k * BE_W));
        end
        return "";
    endfunction

    // Backing memory: random request stalls, in-order read responses
    initial begin
        logic [ADDR_W-1:0] a;
        txn_t t;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_req_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rst && pend_q.size() > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
                a = pend_q.pop_front();
                mem_rsp_valid_i = 1'b1;
                mem_rsp_rdata_i = bk_read(a);
                rsp_given++;
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_rdata_i = {$urandom, $urandom};
            end
            #1;
            if (!rst) begin
                pend_q.delete();
                mem_rsp_valid_i = 1'b0;
            end else if (mem_req_valid_o && mem_req_ready_i) begin
                t.we = mem_req_we_o; t.addr = mem_req_addr_o;
                t.wdata = mem_req_wdata_o; t.be = mem_req_be_o;
                log_q.push_back(t);
                if (mem_req_we_o) bk_mem[mem_req_addr_o] = merge(bk_read(mem_req_addr_o),
                                                                 mem_req_wdata_o, mem_req_be_o);
                else pend_q.push_back(mem_req_addr_o);
            end
        end
    end

    // Issue one request and observe its response
    task automatic do_op(input bit we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be,
                         output logic [DATA_W-1:0] rdata, output int lat,
                         output bit timeout, output logic pulse_after,
                         output logic [DATA_W-1:0] rdata_after);
        int g;
        log_q.delete();
        timeout = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_be_i = be;
        #2;
        g = 0;
        while (!req_ready_o && g < 200) begin @(negedge clk); #2; g++; end
        if (g >= 200) timeout = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0; req_we_i = $urandom_range(0, 1) == 1;
        req_addr_i = {$urandom, $urandom}; req_wdata_i = {$urandom, $urandom};
        req_be_i = BE_W'($urandom);
        #2;
        lat = 1;
        while (!rsp_valid_o && lat < 400) begin @(negedge clk); #2; lat++; end
        if (lat >= 400) timeout = 1'b1;
        rdata = rsp_rdata_o;
        @(negedge clk); #2;
        pulse_after = rsp_valid_o;
        rdata_after = rsp_rdata_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== '0) begin
            n_errors++;
            $display("FAIL reset_cpu_side ready=%b rsp_valid=%b rdata=%h, want 1 0 0",
                     req_ready_o, rsp_valid_o, rsp_rdata_o);
        end
        n_checks++;
        if (mem_req_valid_o !== 1'b0 || mem_req_we_o !== 1'b0 || mem_req_addr_o !== '0 ||
            mem_req_wdata_o !== '0 || mem_req_be_o !== '0) begin
            n_errors++;
            $display("FAIL reset_mem_side valid=%b we=%b addr=%h wdata=%h be=%h, want all 0",
                     mem_req_valid_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_be_o);
        end
`ifdef DCACHE_PERF_EN
        n_checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_perf hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Listed scenarios: cold miss, hit, store hit + reload, conflict, store miss
    task automatic test_directed();
        bit                we_t[8];
        logic [ADDR_W-1:0] addr_t[8];
        logic [DATA_W-1:0] wd, rdata, exp_data, rd_after;
        logic [BE_W-1:0]   be;
        logic              pulse;
        bit                hit, to;
        int                lat;
        string             d;
        we_t = '{0, 0, 1, 0, 0, 0, 1, 0};
        addr_t = '{64'h100, 64'h110, 64'h108, 64'h108, 64'h2100, 64'h100, 64'h4000, 64'h4000};
        stall_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wd = we_t[i] ? 64'hAABB_CCDD_EEFF_0011 : 64'h0;
            be = we_t[i] ? 8'h0F : 8'h00;
            model_op(we_t[i], addr_t[i], wd, be, hit, exp_data);
            do_op(we_t[i], addr_t[i], wd, be, rdata, lat, to, pulse, rd_after);
            n_checks++;
            if (to) begin
                n_errors++;
                $display("FAIL dir%0d_timeout handshake not seen within bound", i);
            end
            d = traffic_diff(we_t[i], addr_t[i], wd, be, hit);
            n_checks++;
            if (d != "") begin
                n_errors++;
                $display("FAIL dir%0d_traffic %s", i, d);
            end
            if (!we_t[i]) begin
                n_checks++;
                if (rdata !== exp_data) begin
                    n_errors++;
                    $display("FAIL dir%0d_data got %h want %h", i, rdata, exp_data);
                end
            end
            if (!we_t[i] && hit) begin
                n_checks++;
                if (lat != 1) begin
                    n_errors++;
                    $display("FAIL dir%0d_hit_latency got %0d want 1", i, lat);
                end
            end
            n_checks++;
            if (pulse !== 1'b0 || rd_after !== '0) begin
                n_errors++;
                $display("FAIL dir%0d_pulse rsp_valid=%b rdata=%h after response, want 0 0",
                         i, pulse, rd_after);
            end
            if (i == 3) begin
                n_checks++;
                if (rdata !== 64'h0000_0000_EEFF_0011) begin
                    n_errors++;
                    $display("FAIL dir_store_merge got %h want 0000_0000_eeff_0011", rdata);
                end
            end
        end
`ifdef DCACHE_PERF_EN
        n_checks++;
        if (hit_cnt_o !== 32'(ref_hits) || miss_cnt_o !== 32'(ref_misses)) begin
            n_errors++;
            $display("FAIL dir_perf hit=%0d miss=%0d want %0d %0d",
                     hit_cnt_o, miss_cnt_o, ref_hits, ref_misses);
        end
`endif
    endtask

    // Continuous load hits: one accept and one response every 2 cycles
    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_data;
        logic [9:0]        pat;
        bit                hit;
        int                bad_data;
        log_q.delete();
        pat = '0;
        bad_data = 0;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 64'h4008 | 64'($urandom_range(0, 7));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); #2;
            pat[c-1] = rsp_valid_o;
            if (rsp_valid_o) begin
                model_op(1'b0, req_addr_i, '0, '0, hit, exp_data);
                if (rsp_rdata_o !== exp_data) bad_data++;
            end
            if (c == 10) req_valid_i = 1'b0;
        end
        n_checks++;
        if (pat !== 10'b01_0101_0101) begin
            n_errors++;
            $display("FAIL b2b_pattern got %b want 0101010101", pat);
        end
        n_checks++;
        if (bad_data != 0 || log_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_data %0d bad words, %0d mem txns, want 0 0", bad_data, log_q.size());
        end
    endtask

    // Reset after the second refill response; the line must not survive
    task automatic test_reset_mid_refill();
        logic [DATA_W-1:0] rdata, exp_data, rd_after;
        logic              pulse;
        bit                hit, to;
        int                lat, g, start;
        string             d;
        stall_en = 1'b0;
        start = rsp_given;
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 64'h300;
        #2;
        g = 0;
        while (!req_ready_o && g < 50) begin @(negedge clk); #2; g++; end
        @(negedge clk);
        req_valid_i = 1'b0;
        #2;
        while (rsp_given < start + 2 && g < 100) begin @(negedge clk); #2; g++; end
        n_checks++;
        if (g >= 100) begin
            n_errors++;
            $display("FAIL midrst_wait responses seen %0d want 2", rsp_given - start);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_rdata_o !== '0 ||
            mem_req_valid_o !== 1'b0 || mem_req_we_o !== 1'b0 || mem_req_addr_o !== '0 ||
            mem_req_wdata_o !== '0 || mem_req_be_o !== '0) begin
            n_errors++;
            $display("FAIL midrst_outputs ready=%b rsp=%b rdata=%h mvalid=%b mwe=%b maddr=%h, want 1 and zeros",
                     req_ready_o, rsp_valid_o, rsp_rdata_o, mem_req_valid_o, mem_req_we_o, mem_req_addr_o);
        end
`ifdef DCACHE_PERF_EN
        n_checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            n_errors++;
            $display("FAIL midrst_perf hit=%0d miss=%0d want 0 0", hit_cnt_o, miss_cnt_o);
        end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            logic [ADDR_W-1:0] a;
            a = (i == 2) ? 64'h100 : 64'h300;
            model_op(1'b0, a, '0, '0, hit, exp_data);
            do_op(1'b0, a, '0, '0, rdata, lat, to, pulse, rd_after);
            d = traffic_diff(1'b0, a, '0, '0, hit);
            n_checks++;
            if (to || d != "") begin
                n_errors++;
                $display("FAIL midrst_reload%0d_traffic timeout=%0b %s", i, to, d);
            end
            n_checks++;
            if (rdata !== exp_data) begin
                n_errors++;
                $display("FAIL midrst_reload%0d_data got %h want %h", i, rdata, exp_data);
            end
        end
    endtask

    // Random loads/stores over a few tags and indices with random memory stalls
    task automatic test_random();
        logic [DATA_W-1:0] wd, rdata, exp_data, rd_after;
        logic [ADDR_W-1:0] addr, tag;
        logic [BE_W-1:0]   be;
        logic              pulse;
        bit                we, hit, to;
        int                lat, sel;
        string             d;
        stall_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            sel  = $urandom_range(0, 3);
            tag  = (sel == 3) ? (64'h1 << 54) : ((sel == 2) ? 64'd16 : 64'(sel));
            addr = (tag << 9) | (64'($urandom_range(0, 3)) << 5) |
                   (64'($urandom_range(0, 3)) << 3) | 64'($urandom_range(0, 7));
            we   = ($urandom_range(0, 2) == 0);
            wd   = {$urandom, $urandom};
            be   = BE_W'($urandom);
            model_op(we, addr, wd, be, hit, exp_data);
            do_op(we, addr, wd, be, rdata, lat, to, pulse, rd_after);
            d = traffic_diff(we, addr, wd, be, hit);
            n_checks++;
            if (to || d != "") begin
                n_errors++;
                $display("FAIL rnd%0d_traffic addr=%h we=%0b timeout=%0b %s", i, addr, we, to, d);
            end
            if (!we) begin
                n_checks++;
                if (rdata !== exp_data || (hit && lat != 1)) begin
                    n_errors++;
                    $display("FAIL rnd%0d_load addr=%h got %h lat %0d want %h lat %s",
                             i, addr, rdata, lat, exp_data, hit ? "1" : "any");
                end
            end
            n_checks++;
            if (pulse !== 1'b0 || rd_after !== '0) begin
                n_errors++;
                $display("FAIL rnd%0d_pulse rsp_valid=%b rdata=%h after response, want 0 0",
                         i, pulse, rd_after);
            end
        end
`ifdef DCACHE_PERF_EN
        n_checks++;
        if (hit_cnt_o !== 32'(ref_hits) || miss_cnt_o !== 32'(ref_misses)) begin
            n_errors++;
            $display("FAIL rnd_perf hit=%0d miss=%0d want %0d %0d",
                     hit_cnt_o, miss_cnt_o, ref_hits, ref_misses);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_refill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hang guard
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
